// File: rtl/uart_tx_arbiter.sv
// Two-requester round-robin arbiter that feeds single bytes into a UART
// transmitter and watches tx_busy to pace the next grant.
module uart_tx_arbiter #(
  parameter int START_TIMEOUT = 15
) (
  input  logic       clk_50m,
  input  logic       rst,
  input  logic       a_valid,
  input  logic [7:0] a_data,
  output logic       a_ready,
  input  logic       b_valid,
  input  logic [7:0] b_data,
  output logic       b_ready,
  output logic [7:0] din,
  output logic       wr_en,
  input  logic       tx_busy,
  output logic       grant_b,
  output logic       timeout_err
);

  localparam int CW_MIN = $clog2(START_TIMEOUT + 1);
  localparam int CW     = (CW_MIN < 4) ? 4 : CW_MIN;
  localparam logic [CW-1:0] CNT_LAST = CW'(START_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_START,
    WAIT_DONE
  } state_e;

  state_e        state_q;
  logic [7:0]    hold_q;
  logic [7:0]    hold_d;
  logic          grant_b_q;
  logic          wr_en_q;
  logic          timeout_err_q;
  logic [CW-1:0] cnt_q;

  logic accept;
  logic pick_b;

  // B wins when it is alone, or on a tie when A was served last.
  always_comb begin
    accept = (state_q == IDLE) && !rst && !tx_busy && (a_valid || b_valid);
    pick_b = b_valid && (!a_valid || !grant_b_q);
    hold_d = pick_b ? b_data : a_data;
  end

  assign a_ready     = accept && !pick_b;
  assign b_ready     = accept && pick_b;
  assign din         = hold_q;
  assign wr_en       = wr_en_q;
  assign grant_b     = grant_b_q;
  assign timeout_err = timeout_err_q;

  always_ff @(posedge clk_50m) begin
    if (rst) begin
      state_q       <= IDLE;
      hold_q        <= 8'h00;
      grant_b_q     <= 1'b1;
      wr_en_q       <= 1'b0;
      timeout_err_q <= 1'b0;
      cnt_q         <= '0;
    end else begin
      wr_en_q       <= 1'b0;
      timeout_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            hold_q    <= hold_d;
            grant_b_q <= pick_b;
            wr_en_q   <= 1'b1;
            state_q   <= ISSUE;
          end
        end
        ISSUE: begin
          cnt_q   <= '0;
          state_q <= WAIT_START;
        end
        // The exit on CNT_LAST keeps the counter from ever wrapping.
        WAIT_START: begin
          if (tx_busy) begin
            state_q <= WAIT_DONE;
          end else if (cnt_q == CNT_LAST) begin
            timeout_err_q <= 1'b1;
            state_q       <= IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        WAIT_DONE: begin
          if (!tx_busy) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: inputs change on the falling edge and
// outputs are checked 1 ns later against hand-computed values.
module tb_uart_tx_arbiter;

  logic       clk50m;
  logic       rst;
  logic       aValid;
  logic [7:0] aData;
  logic       aReady;
  logic       bValid;
  logic [7:0] bData;
  logic       bReady;
  logic [7:0] din;
  logic       wrEn;
  logic       txBusy;
  logic       grantB;
  logic       timeoutErr;

  int checks;
  int errors;

  uart_tx_arbiter #(.START_TIMEOUT(15)) dut (
    .clk_50m     (clk50m),
    .rst         (rst),
    .a_valid     (aValid),
    .a_data      (aData),
    .a_ready     (aReady),
    .b_valid     (bValid),
    .b_data      (bData),
    .b_ready     (bReady),
    .din         (din),
    .wr_en       (wrEn),
    .tx_busy     (txBusy),
    .grant_b     (grantB),
    .timeout_err (timeoutErr)
  );

  initial clk50m = 1'b0;
  always #5 clk50m = ~clk50m;

  task automatic applyStimulus(input logic r, input logic av, input logic [7:0] ad,
                               input logic bv, input logic [7:0] bd, input logic busy);
    @(negedge clk50m);
    rst    = r;
    aValid = av;
    aData  = ad;
    bValid = bv;
    bData  = bd;
    txBusy = busy;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] observed,
                             input logic [7:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  initial begin
    logic       expB;
    logic [7:0] expData;
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    aValid = 1'b0;
    aData  = 8'h00;
    bValid = 1'b0;
    bData  = 8'h00;
    txBusy = 1'b0;

    // Reset values, with both requesters already asking.
    applyStimulus(1, 1, 8'h41, 1, 8'h22, 0);
    applyStimulus(1, 1, 8'h41, 1, 8'h22, 0);
    checkOutput("rstAReady", aReady, 0);
    checkOutput("rstBReady", bReady, 0);
    checkOutput("rstWrEn", wrEn, 0);
    checkOutput("rstTimeout", timeoutErr, 0);
    checkOutput("rstGrantB", grantB, 1);
    checkOutput("rstDin", din, 8'h00);

    // Single A request; A drops valid right after acceptance.
    applyStimulus(0, 1, 8'h41, 0, 8'h00, 0);
    checkOutput("aOnlyReady", aReady, 1);
    checkOutput("aOnlyBReady", bReady, 0);
    applyStimulus(0, 0, 8'h41, 0, 8'h00, 0);
    checkOutput("aOnlyWrEn", wrEn, 1);
    checkOutput("aOnlyDin", din, 8'h41);
    checkOutput("aOnlyGrant", grantB, 0);
    checkOutput("issueNoReady", aReady, 0);
    applyStimulus(0, 0, 8'h00, 0, 8'h00, 1);
    checkOutput("wrEnOneCycle", wrEn, 0);
    checkOutput("dinStable", din, 8'h41);
    applyStimulus(0, 1, 8'h55, 0, 8'h00, 1);
    checkOutput("doneNoReady", aReady, 0);
    checkOutput("doneDinStable", din, 8'h41);
    applyStimulus(0, 1, 8'h55, 0, 8'h00, 0);
    checkOutput("doneExitNoReady", aReady, 0);
    applyStimulus(0, 1, 8'h55, 0, 8'h00, 0);
    checkOutput("secondAccept", aReady, 1);
    applyStimulus(0, 0, 8'h55, 0, 8'h00, 0);
    checkOutput("secondWrEn", wrEn, 1);
    checkOutput("secondDin", din, 8'h55);
    applyStimulus(0, 0, 8'h00, 0, 8'h00, 1);
    applyStimulus(0, 0, 8'h00, 0, 8'h00, 0);

    // Busy UART blocks acceptance in IDLE.
    applyStimulus(0, 1, 8'h66, 0, 8'h00, 1);
    checkOutput("busyNoReady0", aReady, 0);
    applyStimulus(0, 1, 8'h66, 0, 8'h00, 1);
    checkOutput("busyNoReady1", aReady, 0);
    checkOutput("busyNoWrEn", wrEn, 0);
    applyStimulus(0, 1, 8'h66, 0, 8'h00, 0);
    checkOutput("busyFreeReady", aReady, 1);
    applyStimulus(0, 0, 8'h66, 0, 8'h00, 0);
    checkOutput("busyFreeWrEn", wrEn, 1);
    checkOutput("busyFreeDin", din, 8'h66);
    applyStimulus(0, 0, 8'h00, 0, 8'h00, 1);
    applyStimulus(0, 0, 8'h00, 0, 8'h00, 0);

    // Round-robin from reset: UART busy for 10 cycles starting 1 cycle after wr_en.
    applyStimulus(1, 0, 8'h00, 0, 8'h00, 0);
    for (int i = 0; i < 4; i++) begin
      expB    = i[0];
      expData = expB ? 8'h22 : 8'h11;
      applyStimulus(0, 1, 8'h11, 1, 8'h22, 0);
      checkOutput($sformatf("rrAReady%0d", i), aReady, {7'd0, ~expB});
      checkOutput($sformatf("rrBReady%0d", i), bReady, {7'd0, expB});
      applyStimulus(0, 1, 8'h11, 1, 8'h22, 0);
      checkOutput($sformatf("rrWrEn%0d", i), wrEn, 1);
      checkOutput($sformatf("rrDin%0d", i), din, expData);
      checkOutput($sformatf("rrGrant%0d", i), grantB, {7'd0, expB});
      for (int j = 0; j < 10; j++) begin
        applyStimulus(0, 1, 8'h11, 1, 8'h22, 1);
        if (j == 0) begin
          checkOutput($sformatf("rrBusyWrEn%0d", i), wrEn, 0);
          checkOutput($sformatf("rrBusyReady%0d", i), {6'd0, aReady, bReady}, 0);
        end
      end
      applyStimulus(0, 1, 8'h11, 1, 8'h22, 0);
    end

    // UART never starts: timeout 15 cycles after entering WAIT_START.
    applyStimulus(0, 1, 8'h77, 0, 8'h00, 0);
    checkOutput("toAccept", aReady, 1);
    applyStimulus(0, 0, 8'h77, 0, 8'h00, 0);
    checkOutput("toWrEn", wrEn, 1);
    checkOutput("toDin", din, 8'h77);
    for (int i = 0; i < 15; i++) begin
      applyStimulus(0, 0, 8'h00, 0, 8'h00, 0);
      checkOutput($sformatf("toQuiet%0d", i), timeoutErr, 0);
    end
    applyStimulus(0, 1, 8'h88, 0, 8'h00, 0);
    checkOutput("toPulse", timeoutErr, 1);
    checkOutput("toReaccept", aReady, 1);
    applyStimulus(0, 0, 8'h88, 0, 8'h00, 0);
    checkOutput("toPulseEnd", timeoutErr, 0);
    checkOutput("toNextWrEn", wrEn, 1);
    checkOutput("toNextDin", din, 8'h88);
    checkOutput("toNextGrant", grantB, 0);
    applyStimulus(0, 0, 8'h00, 0, 8'h00, 1);
    applyStimulus(0, 1, 8'h3C, 1, 8'h5A, 1);
    checkOutput("wdNoReady", aReady, 0);

    // Reset in WAIT_DONE abandons the byte; A wins the first post-reset tie.
    applyStimulus(1, 1, 8'h3C, 1, 8'h5A, 1);
    checkOutput("midRstAReady", aReady, 0);
    checkOutput("midRstBReady", bReady, 0);
    applyStimulus(0, 1, 8'h3C, 1, 8'h5A, 1);
    checkOutput("postRstWrEn", wrEn, 0);
    checkOutput("postRstTimeout", timeoutErr, 0);
    checkOutput("postRstGrant", grantB, 1);
    checkOutput("postRstDin", din, 8'h00);
    checkOutput("postRstBusyReady", {6'd0, aReady, bReady}, 0);
    applyStimulus(0, 1, 8'h3C, 1, 8'h5A, 1);
    checkOutput("postRstBusyWrEn", wrEn, 0);
    applyStimulus(0, 1, 8'h3C, 1, 8'h5A, 0);
    checkOutput("postRstAReady", aReady, 1);
    checkOutput("postRstBReady", bReady, 0);
    applyStimulus(0, 0, 8'h3C, 0, 8'h5A, 0);
    checkOutput("postRstIssueWrEn", wrEn, 1);
    checkOutput("postRstIssueDin", din, 8'h3C);
    checkOutput("postRstIssueGrant", grantB, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter START_TIMEOUT, default 15: max cycles waited in WAIT_START for tx_busy to rise.
REQ-002 SHALL have port clk_50m, input, 1: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-004 SHALL have port a_valid, input, 1: requester A has a byte to send.
REQ-005 SHALL have port a_data, input, 8: requester A byte.
REQ-006 SHALL have port a_ready, output, 1: requester A byte accepted this cycle.
REQ-007 SHALL have port b_valid, input, 1: requester B has a byte to send.
REQ-008 SHALL have port b_data, input, 8: requester B byte.
REQ-009 SHALL have port b_ready, output, 1: requester B byte accepted this cycle.
REQ-010 SHALL have port din, output, 8: byte to the UART transmitter.
REQ-011 SHALL have port wr_en, output, 1: one-cycle UART write strobe.
REQ-012 SHALL have port tx_busy, input, 1: UART transmitter busy.
REQ-013 SHALL have port grant_b, output, 1: registered; 0 = last accepted byte from A, 1 = from B.
REQ-014 SHALL have port timeout_err, output, 1: one-cycle pulse on WAIT_START timeout.

Function
REQ-015 SHALL implement FSM states IDLE, ISSUE, WAIT_START, WAIT_DONE.
REQ-016 IDLE: if tx_busy=0 and any valid, accept exactly one requester: assert its ready combinationally that cycle, latch its data into an 8-bit hold register, update grant_b, go to ISSUE.
REQ-017 IDLE with tx_busy=1 SHALL accept nothing (a_ready=b_ready=0) and stay in IDLE.
REQ-018 Arbitration: only one valid -> that one; both valid -> the requester not granted last (round-robin); after reset, A has priority.
REQ-019 ready SHALL be asserted only in IDLE and at most one of a_ready/b_ready per cycle; never asserted without its valid.
REQ-020 ISSUE: wr_en=1 for exactly this one cycle, din = hold register; next state WAIT_START.
REQ-021 din SHALL equal the hold register in all states (stable throughout transmission).
REQ-022 WAIT_START: tx_busy=1 -> WAIT_DONE; else count cycles; after START_TIMEOUT cycles with tx_busy=0 -> pulse timeout_err one cycle, go to IDLE.
REQ-023 WAIT_DONE: stay while tx_busy=1; on tx_busy=0 go to IDLE.
REQ-024 Accept-to-wr_en latency SHALL be exactly 1 cycle; min accept-to-next-accept spacing 4 cycles (IDLE, ISSUE, WAIT_START, WAIT_DONE).
REQ-025 Timeout counter SHALL be 4 bits wide minimum (clog2(START_TIMEOUT+1)), cleared on entry to WAIT_START, never wraps.
REQ-026 valid dropped by requester after acceptance SHALL have no effect on the byte in flight.
REQ-027 A requester holding valid while the other is being served SHALL be served next (no starvation).

Reset
REQ-028 rst=1 SHALL force next state IDLE, wr_en=0, a_ready=0, b_ready=0, timeout_err=0, grant_b=1 (so A wins first tie), hold register=8'h00, timeout counter=0.
REQ-029 rst asserted mid-transmission SHALL abandon the in-flight byte without a further wr_en; first post-reset accept SHALL wait for tx_busy=0.
REQ-030 Outputs during rst SHALL be the reset values, including the combinational ready outputs (forced 0).

Verification
REQ-031 A only: a_valid=1, a_data=8'h41, tx_busy=0 -> a_ready 1 cycle, wr_en next cycle with din=8'h41, grant_b=0.
REQ-032 Both valid continuously (A=8'h11, B=8'h22), UART model raises tx_busy 1 cycle after wr_en for 10 cycles -> wr_en sequence 11,22,11,22; grant_b alternates 0,1,0,1.
REQ-033 tx_busy held 1 in IDLE with a_valid=1 -> a_ready=0 until tx_busy falls, then accepted.
REQ-034 UART model never raises tx_busy -> timeout_err pulses exactly START_TIMEOUT cycles after the WAIT_START entry, FSM back in IDLE, next byte accepted.
REQ-035 rst pulsed during WAIT_DONE -> all outputs at reset values next cycle, no wr_en until new accept after tx_busy=0; with both valid, A wins.
